// File: rtl/kb_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package kb_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} kb_state_e;

   localparam logic [7:0] BREAK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE   = 8'hE0;
   localparam int         DATA_BITS  = 8;

   // Odd parity over data plus parity bit means the frame is good.
   function automatic logic frame_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
      return ^{d, p};
   endfunction
endpackage

// File: rtl/ps2_edge_filter.sv
// Synchroniser plus stability filter for the PS/2 clock; emits a one-cycle pulse on a filtered fall.
module ps2_edge_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pin,
   output logic o_fall
);
   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_level;
   logic [CW-1:0]          r_cnt;
   logic                   r_fall;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign o_fall = r_fall;

   always_ff @(posedge clk) begin
      if (rst) r_sync <= '1;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
   end

   // Level only moves after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_level <= 1'b1;
         r_cnt   <= '0;
         r_fall  <= 1'b0;
      end else begin
         r_fall <= 1'b0;
         if (w_sync != r_level) begin
            if (r_cnt == CW'(FILTER_LEN-1)) begin
               r_level <= w_sync;
               r_cnt   <= '0;
               r_fall  <= ~w_sync;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end
endmodule

// File: rtl/ps2_kb_receiver.sv
// PS/2 keyboard frame receiver presenting the last scan code as a level for the CPU.
// Optional build macro KB_BREAK_FILTER_EN hides break sequences (F0 xx) so only make codes appear.
module ps2_kb_receiver
   import kb_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       main_clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] kb_data,
   output logic       kb_strobe,
   output logic       kb_err
);
   localparam int BW = $clog2(DATA_BITS);
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   kb_state_e              r_state, w_state_nxt;
   logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
   logic [BW-1:0]          r_bit_cnt, w_bit_cnt_nxt;
   logic                   r_parity, w_parity_nxt;
   logic [TW-1:0]          r_to_cnt, w_to_cnt_nxt;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic [7:0]             r_kb_data;
   logic                   r_strobe, r_err;
   logic                   w_fall, w_data, w_timeout, w_accept, w_err;
`ifdef KB_BREAK_FILTER_EN
   logic                   r_break_pending;
`endif

   assign kb_data   = r_kb_data;
   assign kb_strobe = r_strobe;
   assign kb_err    = r_err;

   ps2_edge_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_clk_filt (
      .clk    (main_clk),
      .rst    (rst),
      .i_pin  (ps2_clk),
      .o_fall (w_fall)
   );

   always_ff @(posedge main_clk) begin
      if (rst) r_data_sync <= '1;
      else     r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
   end

   assign w_data    = r_data_sync[SYNC_STAGES-1];
   assign w_timeout = (r_to_cnt == TW'(TIMEOUT_CYCLES-1));

   always_ff @(posedge main_clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_parity  <= 1'b0;
         r_to_cnt  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_parity  <= w_parity_nxt;
         r_to_cnt  <= w_to_cnt_nxt;
      end
   end

   // A fall in the expiry cycle is treated as a normal bit, so it is checked first.
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_cnt_nxt = r_bit_cnt;
      w_parity_nxt  = r_parity;
      w_to_cnt_nxt  = r_to_cnt;
      w_accept      = 1'b0;
      w_err         = 1'b0;
      if (w_fall) begin
         w_to_cnt_nxt = '0;
         case (r_state)
            IDLE: begin
               if (!w_data) begin
                  w_state_nxt   = DATA;
                  w_shift_nxt   = '0;
                  w_bit_cnt_nxt = '0;
               end else begin
                  w_err = 1'b1;
               end
            end
            DATA: begin
               w_shift_nxt   = {w_data, r_shift[DATA_BITS-1:1]};
               w_bit_cnt_nxt = r_bit_cnt + 1'b1;
               if (r_bit_cnt == BW'(DATA_BITS-1)) w_state_nxt = PARITY;
            end
            PARITY: begin
               w_parity_nxt = w_data;
               w_state_nxt  = STOP;
            end
            STOP: begin
               w_state_nxt = IDLE;
               if (w_data && frame_parity_ok(r_shift, r_parity)) w_accept = 1'b1;
               else                                              w_err    = 1'b1;
            end
            default: w_state_nxt = IDLE;
         endcase
      end else if (r_state == IDLE) begin
         w_to_cnt_nxt = '0;
      end else if (w_timeout) begin
         w_state_nxt   = IDLE;
         w_shift_nxt   = '0;
         w_bit_cnt_nxt = '0;
         w_to_cnt_nxt  = '0;
         w_err         = 1'b1;
      end else begin
         w_to_cnt_nxt = r_to_cnt + 1'b1;
      end
   end

   always_ff @(posedge main_clk) begin
      if (rst) begin
         r_kb_data <= 8'h00;
         r_strobe  <= 1'b0;
         r_err     <= 1'b0;
`ifdef KB_BREAK_FILTER_EN
         r_break_pending <= 1'b0;
`endif
      end else begin
         r_strobe <= 1'b0;
         r_err    <= w_err;
         if (w_accept) begin
`ifdef KB_BREAK_FILTER_EN
            if (r_shift == BREAK_CODE) begin
               r_break_pending <= 1'b1;
            end else if (r_break_pending) begin
               r_break_pending <= 1'b0;
            end else begin
               r_kb_data <= r_shift;
               r_strobe  <= 1'b1;
            end
`else
            r_kb_data <= r_shift;
            r_strobe  <= 1'b1;
`endif
         end
      end
   end
endmodule
